gnn_0_example_axi_read_master: RTL and testbench

//  - AXI4 read master directly upstream of gnn_0_example_load.
//  - Turns one (start address, byte size) request into a sequence of AR bursts.
//  - Streams the R beats onto the load stage's data_t* interface, with tlast marking the final beat of the whole transfer.
//  - Pulses read_done when the transfer is complete. Read path only; no write channels.

---
 rtl/gnn_0_axi_pkg.sv | 7 +
 rtl/gnn_0_example_ar_issuer.sv | 63 ++++++
 rtl/gnn_0_example_axi_read_master.sv | 80 ++++++++
 tb/tb_gnn_0_example_axi_read_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_0_axi_pkg.sv
// gnn_0_axi_pkg: shared beat geometry and read-master state encoding.
package gnn_0_axi_pkg;
    localparam int BEAT_BYTES   = 64;
    localparam int BEAT_SHIFT   = 6;
    localparam int AXI_4K_BYTES = 4096;
    typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;
endpackage

// File: rtl/gnn_0_example_ar_issuer.sv
// gnn_0_example_ar_issuer: AR burst generation with outstanding-burst limit.
// AXI_READ_MASTER_4K_SPLIT_EN clips each burst at the next 4 KiB boundary.
module gnn_0_example_ar_issuer
    import gnn_0_axi_pkg::*;
#(
    parameter int AW        = 64,
    parameter int BW        = 27,
    parameter int MAX_BURST = 64,
    parameter int MAX_OUT   = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          active,
    input  logic [AW-1:0] start_addr,
    input  logic [BW-1:0] beats,
    input  logic          arready,
    input  logic          r_last_hs,
    output logic          arvalid,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen
);
    localparam int OW = $clog2(MAX_OUT) + 1;
    logic [AW-1:0] next_addr;
    logic [BW-1:0] beats_left, len;
    logic [OW-1:0] outstanding;
    logic          issue, ar_hs;
`ifdef AXI_READ_MASTER_4K_SPLIT_EN
    logic [BW-1:0] room;
    assign room = BW'((AXI_4K_BYTES - int'(next_addr[11:0])) >> BEAT_SHIFT);
`endif
    always_comb begin
        len = (beats_left < BW'(MAX_BURST)) ? beats_left : BW'(MAX_BURST);
`ifdef AXI_READ_MASTER_4K_SPLIT_EN
        len = (room < len) ? room : len;
`endif
    end
    // Only one burst sits on AR at a time; a new one is prepared once the last is accepted.
    assign issue = active && !arvalid && beats_left != '0 && outstanding < OW'(MAX_OUT);
    assign ar_hs = arvalid & arready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_addr   <= '0;
            beats_left  <= '0;
            outstanding <= '0;
            arvalid     <= 1'b0;
            araddr      <= '0;
            arlen       <= '0;
        end else begin
            if (load) begin
                next_addr  <= start_addr;
                beats_left <= beats;
            end else if (issue) begin
                next_addr  <= next_addr + (AW'(len) << BEAT_SHIFT);
                beats_left <= beats_left - len;
                araddr     <= next_addr;
                arlen      <= 8'(len - BW'(1));
            end
            arvalid     <= issue ? 1'b1 : ar_hs ? 1'b0 : arvalid;
            outstanding <= outstanding + OW'(ar_hs) - OW'(r_last_hs);
        end
    end
endmodule

// File: rtl/gnn_0_example_axi_read_master.sv
// gnn_0_example_axi_read_master: AXI4 read master streaming a byte range to the load stage.
// Define AXI_READ_MASTER_4K_SPLIT_EN to split bursts at 4 KiB boundaries.
module gnn_0_example_axi_read_master
    import gnn_0_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_BURST_LEN    = 64,
    parameter int C_MAX_OUTSTANDING  = 4
)(
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          read_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
    output logic                          read_done,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          data_tvalid,
    input  logic                          data_tready,
    output logic                          data_tlast,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata
);
    localparam int BW = C_XFER_SIZE_WIDTH - BEAT_SHIFT + 1;
    localparam int SW = C_XFER_SIZE_WIDTH + 1;
    rd_state_t     state, state_nxt;
    logic [BW-1:0] data_beats_left, total_beats;
    logic          run, load, data_hs, r_last_hs;
    // One spare bit keeps the round-up of an all-ones size from wrapping.
    assign total_beats = BW'((SW'(dram_xfer_size_in_bytes) + SW'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
    assign run         = state == RUN;
    assign load        = state == IDLE && read_start && dram_xfer_size_in_bytes != '0;
    assign data_tvalid = m_axi_rvalid & run;
    assign m_axi_rready = data_tready & run;
    assign data_tdata  = m_axi_rdata;
    assign data_hs     = data_tvalid & data_tready;
    assign data_tlast  = data_tvalid & (data_beats_left == BW'(1));
    assign r_last_hs   = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign read_done   = state == DONE;
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && read_start) ? (load ? RUN : DONE) :
                    (run && data_tlast && data_tready) ? DONE :
                    (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state           <= IDLE;
            data_beats_left <= '0;
        end else begin
            state           <= state_nxt;
            data_beats_left <= load ? total_beats : data_hs ? data_beats_left - BW'(1) : data_beats_left;
        end
    end
    gnn_0_example_ar_issuer #(
        .AW        (C_M_AXI_ADDR_WIDTH),
        .BW        (BW),
        .MAX_BURST (C_MAX_BURST_LEN),
        .MAX_OUT   (C_MAX_OUTSTANDING)
    ) u_ar_issuer (
        .clk        (aclk),
        .rst_n      (areset_n),
        .load       (load),
        .active     (run),
        .start_addr (dram_xfer_start_addr & ~C_M_AXI_ADDR_WIDTH'(BEAT_BYTES - 1)),
        .beats      (total_beats),
        .arready    (m_axi_arready),
        .r_last_hs  (r_last_hs),
        .arvalid    (m_axi_arvalid),
        .araddr     (m_axi_araddr),
        .arlen      (m_axi_arlen)
    );
endmodule

// File: tb/tb_gnn_0_example_axi_read_master.sv
// tb_gnn_0_example_axi_read_master: directed vectors against an address-patterned AXI slave model.
module tb_gnn_0_example_axi_read_master;
    typedef struct {
        logic [63:0] addr; logic [31:0] size; int beats; int ars;
        logic [63:0] a0; int l0; logic [63:0] al; int ll;
    } vec_t;
    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
`ifdef AXI_READ_MASTER_4K_SPLIT_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif
    logic         aclk = 0, areset_n = 0, read_start = 0;
    logic [63:0]  addr = '0;
    logic [31:0]  size = '0;
    logic         read_done, m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rready, m_axi_rlast = 0;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [511:0] m_axi_rdata = '0, data_tdata;
    logic         data_tvalid, data_tready = 1, data_tlast;
    int total = 0, bad = 0;
    // model state written only by the slave process
    ar_t ar_log[$], arq[$];
    int cyc = 0, beats = 0, beat_i = 0, outst = 0, max_out = 0, done_cnt = 0, done_cyc = 0;
    int data_err = 0, tlast_err = 0, dt_err = 0, arv_seen = 0, stall_cycles = 0, viol = 0;
    // stimulus state written only by the test process
    logic [63:0] exp_base = '0;
    int exp_total = 0, k_base = 0, ar_base = 0, done_base = 0, err_base = 0, start_cyc = 0, hold_end = 0;
    logic r_en = 1, rnd = 0;
    logic ar_hs_q, r_hs_q, rl_q, dhs_q, tl_q, stall_q;
    logic [63:0] a_q, d_q;
    logic [7:0] l_q;
    vec_t v[NV];

    always #5 aclk = ~aclk;

    gnn_0_example_axi_read_master dut (
        .aclk(aclk), .areset_n(areset_n), .read_start(read_start),
        .dram_xfer_start_addr(addr), .dram_xfer_size_in_bytes(size), .read_done(read_done),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .data_tvalid(data_tvalid),
        .data_tready(data_tready), .data_tlast(data_tlast), .data_tdata(data_tdata)
    );

    always @(posedge aclk) begin
        ar_hs_q <= m_axi_arvalid & m_axi_arready;
        stall_q <= m_axi_arvalid & !m_axi_arready;
        a_q     <= m_axi_araddr;
        l_q     <= m_axi_arlen;
        r_hs_q  <= m_axi_rvalid & m_axi_rready;
        rl_q    <= m_axi_rlast;
        dhs_q   <= data_tvalid & data_tready;
        tl_q    <= data_tlast;
        d_q     <= data_tdata[63:0];
    end

    // Slave: returns beat address replicated across the data bus; also scores the stream.
    always @(negedge aclk) begin
        cyc++;
        if (!areset_n) begin
            arq.delete();
            beat_i = 0;
            outst = 0;
            m_axi_rvalid = 0;
            m_axi_rlast = 0;
            m_axi_arready = 0;
        end else begin
            if (stall_q) begin
                stall_cycles++;
                if (m_axi_araddr != a_q || m_axi_arlen != l_q || !m_axi_arvalid) viol++;
            end
            if (ar_hs_q) begin
                arq.push_back('{a_q, l_q});
                ar_log.push_back('{a_q, l_q});
                outst++;
            end
            if (r_hs_q && arq.size() > 0) begin
                if (rl_q) begin
                    arq.delete(0);
                    beat_i = 0;
                    outst--;
                end else beat_i++;
            end
            if (outst > max_out) max_out = outst;
            if (dhs_q != r_hs_q) data_err++;
            if (dhs_q) begin
                if (d_q != exp_base + 64'(beats - k_base) * 64) data_err++;
                if (tl_q != ((beats - k_base) == exp_total - 1)) tlast_err++;
                if (tl_q && !read_done) dt_err++;
                beats++;
            end
            if (read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_axi_arvalid) arv_seen++;
            m_axi_arready = cyc >= hold_end;
            data_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_en && arq.size() > 0) begin
                m_axi_rvalid = 1;
                m_axi_rdata = {8{arq[0].addr + 64'(beat_i) * 64}};
                m_axi_rlast = beat_i == int'(arq[0].len);
            end else m_axi_rvalid = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic start_xfer(input logic [63:0] a, input logic [31:0] s);
        tick();
        exp_base  = a & ~64'h3f;
        exp_total = int'(({32'b0, s} + 64'd63) >> 6);
        k_base    = beats;
        ar_base   = ar_log.size();
        done_base = done_cnt;
        err_base  = data_err + tlast_err + dt_err;
        addr = a;
        size = s;
        read_start = 1;
        start_cyc = cyc;
        tick();
        read_start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == done_base && n < 5000) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt != done_base), 1);
        repeat (3) tick();
        chk("done_once", done_cnt - done_base, 1);
        chk("stream_errs", data_err + tlast_err + dt_err - err_base, 0);
        chk("beats_model", beats - k_base, exp_total);
    endtask

    initial begin
        int s0, v0, a0, d0;
        v[0] = '{64'h0,    32'd128,   2,   1, 64'h0,    1, 64'h0,    1};
        v[1] = '{64'h1000, 32'd16384, 256, 4, 64'h1000, 63, 64'h4000, 63};
        v[2] = '{64'h0,    32'd0,     0,   0, 64'h0,    0, 64'h0,    0};
        v[3] = '{64'h40,   32'd100,   2,   1, 64'h40,   1, 64'h40,   1};
        v[4] = '{64'h2025, 32'd64,    1,   1, 64'h2000, 0, 64'h2000, 0};
        v[5] = '{64'h0,    32'd4160,  65,  2, 64'h0,    63, 64'h1000, 0};
`ifdef AXI_READ_MASTER_4K_SPLIT_EN
        v[6] = '{64'hFC0,  32'd256,   4,   2, 64'hFC0,  0, 64'h1000, 2};
`endif
        repeat (2) tick();
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_tvalid", data_tvalid, 0);
        chk("rst_tlast", data_tlast, 0);
        chk("rst_done", read_done, 0);
        areset_n = 1;
        for (int i = 0; i < NV; i++) begin
            start_xfer(v[i].addr, v[i].size);
            wait_done();
            chk("beats", beats - k_base, v[i].beats);
            chk("ar_count", ar_log.size() - ar_base, v[i].ars);
            if (v[i].ars > 0) begin
                chk("ar_first_addr", ar_log[ar_base].addr, v[i].a0);
                chk("ar_first_len", ar_log[ar_base].len, v[i].l0);
                chk("ar_last_addr", ar_log[ar_log.size() - 1].addr, v[i].al);
                chk("ar_last_len", ar_log[ar_log.size() - 1].len, v[i].ll);
            end
            if (v[i].size == 0) chk("zero_done_lat", done_cyc - start_cyc, 1);
        end
        // AR stalled by the slave, R withheld: address stable, outstanding capped at 4
        hold_end = cyc + 25;
        r_en = 0;
        start_xfer(64'h1000, 32'd32768);
        s0 = stall_cycles;
        v0 = viol;
        repeat (60) tick();
        chk("ar_stall_len", 64'((stall_cycles - s0) >= 20), 1);
        chk("ar_stable", viol - v0, 0);
        chk("ar_cap", ar_log.size() - ar_base, 4);
        chk("outstanding", outst, 4);
        r_en = 1;
        wait_done();
        chk("beats_8burst", beats - k_base, 512);
        chk("ar_count_8burst", ar_log.size() - ar_base, 8);
        chk("max_outstanding", max_out, 4);
        // random backpressure, plus a start pulse mid-run that must be ignored
        rnd = 1;
        start_xfer(64'h0, 32'd4160);
        repeat (20) tick();
        read_start = 1;
        tick();
        read_start = 0;
        wait_done();
        chk("beats_rnd", beats - k_base, 65);
        rnd = 0;
        // reset mid-transfer abandons it silently
        start_xfer(64'h1000, 32'd16384);
        repeat (30) tick();
        areset_n = 0;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_tvalid", data_tvalid, 0);
        chk("mid_rst_tlast", data_tlast, 0);
        chk("mid_rst_done", read_done, 0);
        a0 = arv_seen;
        d0 = done_cnt;
        repeat (2) tick();
        areset_n = 1;
        repeat (20) tick();
        chk("no_done_after_rst", done_cnt - d0, 0);
        chk("no_ar_after_rst", arv_seen - a0, 0);
        start_xfer(64'h0, 32'd128);
        wait_done();
        chk("beats_after_rst", beats - k_base, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
